// File: rtl/battleship_game_ctrl.sv
// rtl/battleship_game_ctrl.sv - turn sequencer for the battleship game
// Tracks ship counts per side and a per-turn player timer; outputs feed the renderer.
module battleship_game_ctrl #(
  parameter int MAX_SHIPS   = 5,
  parameter int SHIP_W      = 3,
  parameter int TURN_CYCLES = 750000000,
  parameter int TIMER_W     = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [SHIP_W-1:0]  ship_count_sel,
  input  logic               ships_decided,
  input  logic               place_confirm,
  input  logic               pc_place_done,
  input  logic               player_fire,
  input  logic               player_sunk,
  input  logic               pc_fire,
  input  logic               pc_sunk,
  output logic               decision_state,
  output logic               colocation_state,
  output logic               setup_state,
  output logic               player_turn_state,
  output logic               pc_turn_state,
  output logic               victory_state,
  output logic               defeat_state,
  output logic [SHIP_W-1:0]  target_ships,
  output logic [SHIP_W-1:0]  player_ships,
  output logic [SHIP_W-1:0]  pc_ships,
  output logic [TIMER_W-1:0] time_left,
  output logic               timeout_pulse
);

  localparam logic [2:0] S_DECISION    = 3'd0;
  localparam logic [2:0] S_COLOCATION  = 3'd1;
  localparam logic [2:0] S_SETUP       = 3'd2;
  localparam logic [2:0] S_PLAYER_TURN = 3'd3;
  localparam logic [2:0] S_PC_TURN     = 3'd4;
  localparam logic [2:0] S_VICTORY     = 3'd5;
  localparam logic [2:0] S_DEFEAT      = 3'd6;

  localparam logic [SHIP_W-1:0]  SHIP_ONE  = SHIP_W'(1);
  localparam logic [SHIP_W-1:0]  SHIP_MAX  = SHIP_W'(MAX_SHIPS);
  localparam logic [TIMER_W-1:0] TIME_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES);

  logic [2:0]        state;
  logic [SHIP_W-1:0] clamped_sel;

  always_comb begin
    clamped_sel = ship_count_sel;
    if (ship_count_sel == '0)
      clamped_sel = SHIP_ONE;
    else if (ship_count_sel > SHIP_MAX)
      clamped_sel = SHIP_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_DECISION;
      target_ships  <= '0;
      player_ships  <= '0;
      pc_ships      <= '0;
      time_left     <= '0;
      timeout_pulse <= 1'b0;
    end else if (restart) begin
      state         <= S_DECISION;
      target_ships  <= '0;
      player_ships  <= '0;
      pc_ships      <= '0;
      time_left     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        S_DECISION: begin
          if (ships_decided) begin
            target_ships <= clamped_sel;
            player_ships <= '0;
            pc_ships     <= '0;
            state        <= S_COLOCATION;
          end
        end
        S_COLOCATION: begin
          if (place_confirm) begin
            player_ships <= player_ships + SHIP_ONE;
            if (player_ships + SHIP_ONE == target_ships)
              state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (pc_place_done) begin
            pc_ships <= pc_ships + SHIP_ONE;
            if (pc_ships + SHIP_ONE == target_ships) begin
              state     <= S_PLAYER_TURN;
              time_left <= TURN_LOAD;
            end
          end
        end
        S_PLAYER_TURN: begin
          // A fire landing on the expiry cycle beats the timeout.
          if (player_fire) begin
            if (player_sunk) begin
              pc_ships <= pc_ships - SHIP_ONE;
              state    <= (pc_ships == SHIP_ONE) ? S_VICTORY : S_PC_TURN;
            end else begin
              state <= S_PC_TURN;
            end
          end else if (time_left == TIME_ONE) begin
            time_left     <= '0;
            timeout_pulse <= 1'b1;
            state         <= S_PC_TURN;
          end else if (time_left != '0) begin
            time_left <= time_left - TIME_ONE;
          end
        end
        S_PC_TURN: begin
          if (pc_fire) begin
            if (pc_sunk && player_ships == SHIP_ONE) begin
              player_ships <= '0;
              state        <= S_DEFEAT;
            end else begin
              if (pc_sunk)
                player_ships <= player_ships - SHIP_ONE;
              state     <= S_PLAYER_TURN;
              time_left <= TURN_LOAD;
            end
          end
        end
        S_VICTORY, S_DEFEAT: ;
        default: state <= S_DECISION;
      endcase
    end
  end

  assign decision_state    = (state == S_DECISION);
  assign colocation_state  = (state == S_COLOCATION);
  assign setup_state       = (state == S_SETUP);
  assign player_turn_state = (state == S_PLAYER_TURN);
  assign pc_turn_state     = (state == S_PC_TURN);
  assign victory_state     = (state == S_VICTORY);
  assign defeat_state      = (state == S_DEFEAT);

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// tb/tb_battleship_game_ctrl.sv - directed self-checking bench for battleship_game_ctrl
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_battleship_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, restart;
  logic [2:0] ship_count_sel;
  logic       ships_decided, place_confirm, pc_place_done;
  logic       player_fire, player_sunk, pc_fire, pc_sunk;
  logic       decision_state, colocation_state, setup_state, player_turn_state;
  logic       pc_turn_state, victory_state, defeat_state;
  logic [2:0] target_ships, player_ships, pc_ships;
  logic [2:0] time_left;
  logic       timeout_pulse;

  int checks = 0;
  int fails  = 0;

  // {decision, colocation, setup, player_turn, pc_turn, victory, defeat}
  logic [6:0] states;
  assign states = {decision_state, colocation_state, setup_state, player_turn_state,
                   pc_turn_state, victory_state, defeat_state};
  localparam logic [6:0] ST_DEC = 7'b1000000;
  localparam logic [6:0] ST_COL = 7'b0100000;
  localparam logic [6:0] ST_SET = 7'b0010000;
  localparam logic [6:0] ST_PLY = 7'b0001000;
  localparam logic [6:0] ST_PC  = 7'b0000100;
  localparam logic [6:0] ST_VIC = 7'b0000010;
  localparam logic [6:0] ST_DEF = 7'b0000001;

  battleship_game_ctrl #(
    .MAX_SHIPS(5), .SHIP_W(3), .TURN_CYCLES(4), .TIMER_W(3)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .ship_count_sel(ship_count_sel),
    .ships_decided(ships_decided), .place_confirm(place_confirm),
    .pc_place_done(pc_place_done), .player_fire(player_fire),
    .player_sunk(player_sunk), .pc_fire(pc_fire), .pc_sunk(pc_sunk),
    .decision_state(decision_state), .colocation_state(colocation_state),
    .setup_state(setup_state), .player_turn_state(player_turn_state),
    .pc_turn_state(pc_turn_state), .victory_state(victory_state),
    .defeat_state(defeat_state), .target_ships(target_ships),
    .player_ships(player_ships), .pc_ships(pc_ships), .time_left(time_left),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1; step(); restart = 1'b0;
  endtask

  task automatic decide(input logic [2:0] sel);
    ship_count_sel = sel; ships_decided = 1'b1; step(); ships_decided = 1'b0;
  endtask

  task automatic place(input int n);
    for (int i = 0; i < n; i++) begin
      place_confirm = 1'b1; step(); place_confirm = 1'b0;
    end
  endtask

  task automatic pc_place(input int n);
    for (int i = 0; i < n; i++) begin
      pc_place_done = 1'b1; step(); pc_place_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    checks++;
    if (states !== ST_DEC) begin
      fails++; $display("FAIL reset_state: got %b expected %b", states, ST_DEC);
    end
    checks++;
    if ({target_ships, player_ships, pc_ships, time_left, timeout_pulse} !== 13'd0) begin
      fails++;
      $display("FAIL reset_counters: got t=%0d p=%0d c=%0d tl=%0d to=%b expected all 0",
               target_ships, player_ships, pc_ships, time_left, timeout_pulse);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_decision_clamp();
    decide(3'd0);
    checks++;
    if (states !== ST_COL || target_ships !== 3'd1) begin
      fails++; $display("FAIL clamp_zero: got state=%b target=%0d expected %b target=1",
                        states, target_ships, ST_COL);
    end
    do_restart();
    decide(3'd7);
    checks++;
    if (states !== ST_COL || target_ships !== 3'd5) begin
      fails++; $display("FAIL clamp_max: got state=%b target=%0d expected %b target=5",
                        states, target_ships, ST_COL);
    end
    // restart beats a simultaneous ships_decided
    restart = 1'b1; ship_count_sel = 3'd3; ships_decided = 1'b1; step();
    restart = 1'b0; ships_decided = 1'b0;
    checks++;
    if (states !== ST_DEC || target_ships !== 3'd0) begin
      fails++; $display("FAIL restart_priority: got state=%b target=%0d expected %b target=0",
                        states, target_ships, ST_DEC);
    end
    decide(3'd3);
    for (int i = 1; i <= 3; i++) begin
      place(1);
      checks++;
      if (player_ships !== 3'(i) || states !== ((i == 3) ? ST_SET : ST_COL)) begin
        fails++; $display("FAIL place_%0d: got ships=%0d state=%b expected ships=%0d",
                          i, player_ships, states, i);
      end
    end
    place(1);
    checks++;
    if (player_ships !== 3'd3 || states !== ST_SET) begin
      fails++; $display("FAIL place_extra: got ships=%0d state=%b expected 3 %b",
                        player_ships, states, ST_SET);
    end
  endtask

  task automatic test_timeout();
    pc_place(3);
    checks++;
    if (states !== ST_PLY || pc_ships !== 3'd3 || time_left !== 3'd4) begin
      fails++; $display("FAIL setup_done: got state=%b pc=%0d tl=%0d expected %b 3 4",
                        states, pc_ships, time_left, ST_PLY);
    end
    for (int i = 3; i >= 1; i--) begin
      step();
      checks++;
      if (time_left !== 3'(i) || states !== ST_PLY || timeout_pulse !== 1'b0) begin
        fails++; $display("FAIL countdown_%0d: got tl=%0d state=%b to=%b expected tl=%0d",
                          i, time_left, states, timeout_pulse, i);
      end
    end
    step();
    checks++;
    if (time_left !== 3'd0 || states !== ST_PC || timeout_pulse !== 1'b1) begin
      fails++; $display("FAIL expiry: got tl=%0d state=%b to=%b expected 0 %b 1",
                        time_left, states, timeout_pulse, ST_PC);
    end
    step();
    checks++;
    if (timeout_pulse !== 1'b0 || player_ships !== 3'd3 || time_left !== 3'd0) begin
      fails++; $display("FAIL after_expiry: got to=%b ps=%0d tl=%0d expected 0 3 0",
                        timeout_pulse, player_ships, time_left);
    end
  endtask

  task automatic test_fire_on_expiry();
    pc_fire = 1'b1; step(); pc_fire = 1'b0;
    checks++;
    if (states !== ST_PLY || time_left !== 3'd4 || player_ships !== 3'd3) begin
      fails++; $display("FAIL pc_miss_reload: got state=%b tl=%0d ps=%0d expected %b 4 3",
                        states, time_left, player_ships, ST_PLY);
    end
    step(); step(); step();
    player_fire = 1'b1; step(); player_fire = 1'b0;
    checks++;
    if (states !== ST_PC || timeout_pulse !== 1'b0 || time_left !== 3'd1 || pc_ships !== 3'd3) begin
      fails++; $display("FAIL fire_at_expiry: got state=%b to=%b tl=%0d pc=%0d expected %b 0 1 3",
                        states, timeout_pulse, time_left, pc_ships, ST_PC);
    end
  endtask

  task automatic test_victory();
    do_restart(); decide(3'd2); place(2); pc_place(2);
    player_fire = 1'b1; player_sunk = 1'b1; step(); player_fire = 1'b0; player_sunk = 1'b0;
    checks++;
    if (pc_ships !== 3'd1 || states !== ST_PC) begin
      fails++; $display("FAIL sink_first: got pc=%0d state=%b expected 1 %b", pc_ships, states, ST_PC);
    end
    pc_fire = 1'b1; step(); pc_fire = 1'b0;
    player_fire = 1'b1; player_sunk = 1'b1; step(); player_fire = 1'b0; player_sunk = 1'b0;
    checks++;
    if (pc_ships !== 3'd0 || states !== ST_VIC) begin
      fails++; $display("FAIL sink_last: got pc=%0d state=%b expected 0 %b", pc_ships, states, ST_VIC);
    end
    {player_fire, player_sunk, pc_fire, pc_sunk, place_confirm, pc_place_done, ships_decided} = 7'h7f;
    step();
    {player_fire, player_sunk, pc_fire, pc_sunk, place_confirm, pc_place_done, ships_decided} = 7'h00;
    checks++;
    if (states !== ST_VIC || pc_ships !== 3'd0 || player_ships !== 3'd2 || target_ships !== 3'd2) begin
      fails++; $display("FAIL victory_frozen: got state=%b pc=%0d ps=%0d t=%0d expected %b 0 2 2",
                        states, pc_ships, player_ships, target_ships, ST_VIC);
    end
    do_restart();
    checks++;
    if (states !== ST_DEC || {target_ships, player_ships, pc_ships, time_left} !== 12'd0) begin
      fails++; $display("FAIL victory_restart: got state=%b t=%0d ps=%0d pc=%0d tl=%0d expected %b zeros",
                        states, target_ships, player_ships, pc_ships, time_left, ST_DEC);
    end
  endtask

  task automatic test_defeat();
    decide(3'd1); place(1); pc_place(1);
    pc_place(1); place(1);
    player_sunk = 1'b1; step(); player_sunk = 1'b0;
    checks++;
    if (states !== ST_PLY || pc_ships !== 3'd1 || player_ships !== 3'd1 || time_left !== 3'd1) begin
      fails++; $display("FAIL stray_pulses: got state=%b pc=%0d ps=%0d tl=%0d expected %b 1 1 1",
                        states, pc_ships, player_ships, time_left, ST_PLY);
    end
    player_fire = 1'b1; step(); player_fire = 1'b0;
    pc_sunk = 1'b1; step(); pc_sunk = 1'b0;
    checks++;
    if (states !== ST_PC || player_ships !== 3'd1) begin
      fails++; $display("FAIL sunk_no_fire: got state=%b ps=%0d expected %b 1", states, player_ships, ST_PC);
    end
    pc_fire = 1'b1; pc_sunk = 1'b1; step(); pc_fire = 1'b0; pc_sunk = 1'b0;
    checks++;
    if (states !== ST_DEF || player_ships !== 3'd0 || pc_ships !== 3'd1) begin
      fails++; $display("FAIL defeat: got state=%b ps=%0d pc=%0d expected %b 0 1",
                        states, player_ships, pc_ships, ST_DEF);
    end
    checks++;
    if (player_ships > target_ships || pc_ships > target_ships) begin
      fails++; $display("FAIL no_wrap: got ps=%0d pc=%0d above target=%0d",
                        player_ships, pc_ships, target_ships);
    end
  endtask

  task automatic test_async_reset();
    do_restart(); decide(3'd2); place(2); pc_place(2); step();
    rst = 1'b1; #1;
    checks++;
    if (states !== ST_DEC || {target_ships, player_ships, pc_ships, time_left, timeout_pulse} !== 13'd0) begin
      fails++; $display("FAIL async_reset: got state=%b t=%0d ps=%0d pc=%0d tl=%0d expected %b zeros",
                        states, target_ships, player_ships, pc_ships, time_left, ST_DEC);
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if (states !== ST_DEC) begin
      fails++; $display("FAIL post_reset_idle: got %b expected %b", states, ST_DEC);
    end
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; ship_count_sel = 3'd0;
    ships_decided = 1'b0; place_confirm = 1'b0; pc_place_done = 1'b0;
    player_fire = 1'b0; player_sunk = 1'b0; pc_fire = 1'b0; pc_sunk = 1'b0;
    test_reset();
    test_decision_clamp();
    test_timeout();
    test_fire_on_expiry();
    test_victory();
    test_defeat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
Parametrised top-level turn controller for the VGA battleship game. It sequences ship-count decision, player placement, PC placement, alternating turns and the win/lose end states. Ship bookkeeping is held in internal counters, so it no longer relies on external ship counts. It adds a per-turn player timeout and a restart path. It sits between the switch/button input logic, the PC AI/randomiser and the VGA renderer, which consumes its state flags and counters.

Parameters:
MAX_SHIPS, 5, upper bound on ships per side; the selected count is clamped to 1..MAX_SHIPS
SHIP_W, 3, counter width; must satisfy 2^SHIP_W > MAX_SHIPS
TURN_CYCLES, 750000000, clock cycles allowed per player turn (15 s at 50 MHz)
TIMER_W, 30, turn timer width; must satisfy 2^TIMER_W > TURN_CYCLES

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
restart  in  1  synchronous soft restart to DECISION
ship_count_sel  in  SHIP_W  requested ship count (switches)
ships_decided  in  1  one-cycle pulse: accept ship_count_sel
place_confirm  in  1  one-cycle pulse: player placed one ship
pc_place_done  in  1  one-cycle pulse: PC placed one ship
player_fire  in  1  one-cycle pulse: player attack resolved
player_sunk  in  1  qualifies player_fire: attack sank a PC ship
pc_fire  in  1  one-cycle pulse: PC attack resolved
pc_sunk  in  1  qualifies pc_fire: attack sank a player ship
decision_state, colocation_state, setup_state, player_turn_state, pc_turn_state, victory_state, defeat_state  out  1 each  one-hot state decode
target_ships  out  SHIP_W  latched clamped ship count
player_ships  out  SHIP_W  player ships afloat
pc_ships  out  SHIP_W  PC ships afloat
time_left  out  TIMER_W  cycles remaining in the current player turn
timeout_pulse  out  1  one-cycle pulse when a player turn expires

Behaviour:
- Reset (async, rst=1): state DECISION; target_ships, player_ships, pc_ships, time_left and timeout_pulse are all 0. Only decision_state is high.
- restart=1 in any state: next cycle is identical to the reset condition. restart has priority over every other input.
- DECISION, on ships_decided:
  - target_ships <= clamp(ship_count_sel); a value of 0 becomes 1, and a value above MAX_SHIPS becomes MAX_SHIPS.
  - player_ships <= 0, pc_ships <= 0.
  - Next state COLOCATION.
- COLOCATION, on place_confirm: player_ships increments. When the incremented value equals target_ships, the next state is SETUP. No further confirms are counted.
- SETUP, on pc_place_done: pc_ships increments. When the incremented value equals target_ships, the next state is PLAYER_TURN and time_left is loaded with TURN_CYCLES.
- PLAYER_TURN:
  - time_left decrements each cycle with no player_fire.
  - On player_fire with player_sunk: pc_ships decrements. If the result is 0, go to VICTORY; otherwise go to PC_TURN.
  - On player_fire without player_sunk: go to PC_TURN with no count change.
  - If time_left==1 and there is no player_fire: time_left becomes 0, timeout_pulse is high for the following cycle, and the next state is PC_TURN.
  - player_fire in the same cycle as expiry: the fire wins and timeout_pulse stays 0.
- PC_TURN:
  - On pc_fire with pc_sunk: player_ships decrements. If the result is 0, go to DEFEAT; otherwise go to PLAYER_TURN.
  - On pc_fire without pc_sunk: go to PLAYER_TURN.
  - Every entry to PLAYER_TURN reloads time_left with TURN_CYCLES.
  - time_left holds its value while in PC_TURN.
- VICTORY and DEFEAT: absorbing. Counters freeze; only restart or rst leaves.
- Pulses that do not belong to the current state are ignored and change no counter. The sunk qualifiers are ignored without their fire pulse.
- Counters never wrap. Decrement at 0 and increment at target_ships are unreachable by construction; the bench asserts this.
- Latency: every transition and counter update is visible one cycle after the qualifying input edge. All outputs are registered or decoded directly from registered state.

Test Plan:
1. rst pulse mid-PLAYER_TURN -> same cycle: decision_state=1, all counters 0, no clock edge needed.
2. ship_count_sel=0, then 7 with MAX_SHIPS=5, each followed by ships_decided -> target_ships=1 and 5 respectively; 3 place_confirms with target 3 -> setup_state after the 3rd, a 4th confirm ignored.
3. TURN_CYCLES=4, no player_fire -> time_left 4,3,2,1,0; timeout_pulse one cycle; pc_turn_state=1; player_ships unchanged.
4. TURN_CYCLES=4, player_fire on the cycle time_left=1 -> PC_TURN, timeout_pulse stays 0.
5. target 2: player_fire+player_sunk twice, each separated by pc_fire without pc_sunk -> pc_ships 2->1->0, victory_state=1; further pulses ignored; restart -> DECISION.
6. target 1: player misses, then pc_fire+pc_sunk -> player_ships=0, defeat_state=1; pc_place_done and place_confirm pulses in PLAYER_TURN change nothing.
